// File: rtl/uart_tx.sv
// uart_tx: UART transmitter that serialises start, LSB-first data, optional parity and stop bits.
module uart_tx #(
  parameter int CLK_FRE     = 50,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                  i_clk_sys,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  output logic                  o_busy,
  output logic                  o_uart_tx,
  output logic                  o_ld_parity
);
  localparam int BAUD_DIV = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int CW = $clog2(BAUD_DIV);
  generate
    if (PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2 || DATA_WIDTH < 5 || DATA_WIDTH > 9 || BAUD_DIV < 4) begin : g_bad_param
      $error("uart_tx: illegal parameter combination");
    end
  endgenerate
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state, state_n;
  logic [CW-1:0]         baud, baud_n;
  logic [3:0]            bits, bits_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  ld_n, tx_n, tick, last;
  assign o_data_ready = state == IDLE;
  assign o_busy       = state != IDLE;
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      baud        <= '0;
      bits        <= '0;
      shreg       <= '0;
      o_ld_parity <= 1'b0;
      o_uart_tx   <= 1'b1;
    end else begin
      state       <= state_n;
      baud        <= baud_n;
      bits        <= bits_n;
      shreg       <= shreg_n;
      o_ld_parity <= ld_n;
      o_uart_tx   <= tx_n;
    end
  end
  always_comb begin
    state_n = state;
    bits_n  = bits;
    shreg_n = shreg;
    ld_n    = o_ld_parity;
    tick    = baud == CW'(BAUD_DIV - 1);
    baud_n  = (state == IDLE || tick) ? '0 : baud + 1'b1;
    last    = bits == 4'(state == DATA ? DATA_WIDTH - 1 : STOP_BITS - 1);
    case (state)
      IDLE: if (i_data_valid) begin
        state_n = START;
        shreg_n = i_data;
        ld_n    = ^i_data;
      end
      START:  if (tick) state_n = DATA;
      DATA: if (tick) begin
        shreg_n = shreg >> 1;
        bits_n  = last ? 4'd0 : bits + 4'd1;
        if (last) state_n = (PARITY_MODE != 0) ? PARITY : STOP;
      end
      PARITY: if (tick) state_n = STOP;
      STOP: if (tick) begin
        bits_n = last ? 4'd0 : bits + 4'd1;
        if (last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // line value is computed for the next state and registered, so the pin never glitches
    tx_n = state_n == START  ? 1'b0 :
           state_n == DATA   ? shreg_n[0] :
           state_n == PARITY ? (PARITY_MODE == 2 ? ld_n : ~ld_n) : 1'b1;
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed vectors over three transmitter variants (no parity, even/2 stop, odd) at BAUD_DIV=8.
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic [2:0] tx, rdy, bsy, ldp;
  int errors = 0, checks = 0;
  int pm[3]   = '{0, 2, 1};
  int flen[3] = '{80, 96, 88};
  typedef struct {logic [7:0] d; logic ld;} vec_t;
  vec_t vecs[5];
  always #5 clk = ~clk;
  uart_tx #(.CLK_FRE(1), .BAUD_RATE(125000)) d0 (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_data(data), .i_data_valid(valid),
    .o_data_ready(rdy[0]), .o_busy(bsy[0]), .o_uart_tx(tx[0]), .o_ld_parity(ldp[0]));
  uart_tx #(.CLK_FRE(1), .BAUD_RATE(125000), .PARITY_MODE(2), .STOP_BITS(2)) d1 (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_data(data), .i_data_valid(valid),
    .o_data_ready(rdy[1]), .o_busy(bsy[1]), .o_uart_tx(tx[1]), .o_ld_parity(ldp[1]));
  uart_tx #(.CLK_FRE(1), .BAUD_RATE(125000), .PARITY_MODE(1)) d2 (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_data(data), .i_data_valid(valid),
    .o_data_ready(rdy[2]), .o_busy(bsy[2]), .o_uart_tx(tx[2]), .o_ld_parity(ldp[2]));
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  function automatic logic [11:0] frame(input logic [7:0] d, input int p);
    frame = '1;
    frame[0] = 1'b0;
    frame[8:1] = d;
    if (p != 0) frame[9] = (p == 2) ? ^d : ~^d;
  endfunction
  task automatic reset_checks(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_tx%0d", tag, i), tx[i], 1);
      chk($sformatf("%s_ready%0d", tag, i), rdy[i], 1);
      chk($sformatf("%s_busy%0d", tag, i), bsy[i], 0);
      chk($sformatf("%s_ldpar%0d", tag, i), ldp[i], 0);
    end
  endtask
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    data = d;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    data = ~d;
    chk("start_low", tx[0], 0);
    chk("busy_rise", bsy[0], 1);
    chk("ready_drop", rdy[0], 0);
  endtask
  // Starts on the negedge right after the transfer edge; samples each bit mid-way for 12 bit times.
  task automatic capture(input logic [7:0] d, input logic ld, input bit inj, input logic [2:0] mask);
    logic [11:0] got[3];
    int bc[3];
    for (int i = 0; i < 3; i++) bc[i] = 0;
    for (int n = 0; n < 104; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (bsy[i]) bc[i]++;
        if (n % 8 == 4 && n < 96) got[i][n/8] = tx[i];
      end
      if (inj && n == 29) begin
        data = 8'hFF;
        valid = 1'b1;
        chk("reject_ready", rdy, 3'b000);
      end
      if (inj && n == 30) begin
        valid = 1'b0;
        data = 8'h00;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) if (mask[i]) begin
      chk($sformatf("frame%0d_%02h", i, d), got[i], frame(d, pm[i]));
      chk($sformatf("busy_len%0d", i), bc[i], flen[i]);
      chk($sformatf("ready_after%0d", i), rdy[i], 1);
      chk($sformatf("ldpar%0d", i), ldp[i], ld);
    end
  endtask
  initial begin
    int k;
    vecs[0] = '{8'hAC, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h01, 1'b1};
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 reset_checks("reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[v]) begin
      send(vecs[v].d);
      capture(vecs[v].d, vecs[v].ld, 1'b0, 3'b111);
    end
    send(8'h07);
    capture(8'h07, 1'b1, 1'b1, 3'b111);
    @(negedge clk);
    data = 8'h55;
    valid = 1'b1;
    @(negedge clk);
    chk("b2b_first_accept", rdy[0], 0);
    data = 8'hA3;
    k = 0;
    while (!rdy[0] && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_gap", k, 80);
    @(negedge clk);
    chk("b2b_ready_pulse", rdy[0], 0);
    chk("b2b_second_start", tx[0], 0);
    valid = 1'b0;
    data = 8'h00;
    capture(8'hA3, 1'b0, 1'b0, 3'b001);
    send(8'h3C);
    repeat (36) @(negedge clk);
    rst_n = 1'b0;
    #1 reset_checks("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h3C);
    capture(8'h3C, 1'b0, 1'b0, 3'b111);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
